// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory
// combinationally and registers the returned word into a valid/ready slot
// for decode. Misaligned or out-of-range fetch targets stop fetch until reset.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   RUN    | fetching; redirects accepted, slot filled when free/draining
//   HALTED | fault seen; slot empty, PC frozen, only reset leaves
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 128,
    parameter int          ADDR_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted,
    output logic [31:0]       fault_pc
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] BYTE_END = 32'(4 * MEM_WORDS);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < BYTE_END);
    endfunction

    // Memory sees the word index of the current PC with no extra latency.
    assign imem_addr = pc[ADDR_W+1:2];

    // Fetch control: redirect beats fault detection beats slot fill/stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_pc    <= 32'h0;
            halted    <= 1'b0;
            fault_pc  <= 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        // Squash the slot even if decode is taking it this cycle.
                        out_valid <= 1'b0;
                        if (addr_legal(redirect_pc)) begin
                            pc <= redirect_pc;
                        end else begin
                            state    <= HALTED;
                            halted   <= 1'b1;
                            fault_pc <= redirect_pc;
                        end
                    end else if (!addr_legal(pc)) begin
                        // Sequential walk ran off the end of memory.
                        state     <= HALTED;
                        halted    <= 1'b1;
                        fault_pc  <= pc;
                        out_valid <= 1'b0;
                    end else if (!out_valid || out_ready) begin
                        out_instr <= imem_instr;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + 32'd4;
                    end
                end
                HALTED: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with cycle-exact
// expectations, then a randomized run scored against the in-order
// instruction stream implied by the redirect history.
module tb_fetch_stage;

    localparam int MEM_WORDS = 128;
    localparam int ADDR_W    = 7;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halted;
    logic [31:0]       fault_pc;

    logic [31:0] mem [MEM_WORDS];

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(MEM_WORDS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    // Advance past one rising edge and land on the following falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'h1000_0000 + 32'(k);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fill_pattern();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        cyc();
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc: got %h expected 0", fault_pc); end
        checks++; if (imem_addr !== 7'd0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] epc;
        fill_pattern();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc();
            epc = 32'(4 * k);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (out_pc !== epc) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, out_pc, epc); end
            checks++; if (out_instr !== 32'h1000_0000 + 32'(k)) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, out_instr, 32'h1000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_backpressure();
        fill_pattern();
        do_reset();
        cyc(); cyc(); cyc();
        checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL bp_setup_pc: got %h expected 8", out_pc); end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected 8", k, out_pc); end
            checks++; if (out_instr !== 32'h1000_0002) begin errors++; $display("FAIL bp_instr[%0d]: got %h expected 10000002", k, out_instr); end
            checks++; if (imem_addr !== 7'd3) begin errors++; $display("FAIL bp_imem_addr[%0d]: got %h expected 3", k, imem_addr); end
        end
        out_ready = 1'b1;
        cyc();
        checks++; if (out_pc !== 32'hC) begin errors++; $display("FAIL bp_release_pc: got %h expected c", out_pc); end
        checks++; if (out_instr !== 32'h1000_0003) begin errors++; $display("FAIL bp_release_instr: got %h expected 10000003", out_instr); end
        cyc();
        checks++; if (out_pc !== 32'h10) begin errors++; $display("FAIL bp_next_pc: got %h expected 10", out_pc); end
    endtask

    task automatic test_redirect();
        fill_pattern();
        do_reset();
        cyc(); cyc();
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL redir_setup_pc: got %h expected 4", out_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 7'h10) begin errors++; $display("FAIL redir_imem_addr: got %h expected 10", imem_addr); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_target_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL redir_target_pc: got %h expected 40", out_pc); end
        checks++; if (out_instr !== 32'h1000_0010) begin errors++; $display("FAIL redir_target_instr: got %h expected 10000010", out_instr); end
        cyc();
        checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL redir_follow_pc: got %h expected 44", out_pc); end
    endtask

    task automatic test_misaligned();
        fill_pattern();
        do_reset();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL mis_halted: got %b expected 1", halted); end
        checks++; if (fault_pc !== 32'h42) begin errors++; $display("FAIL mis_fault_pc: got %h expected 42", fault_pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 7'd1) begin errors++; $display("FAIL mis_pc_frozen: got %h expected 1", imem_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL mis_stay_halted[%0d]: got valid=%b halted=%b expected valid=0 halted=1", k, out_valid, halted); end
        end
        checks++; if (fault_pc !== 32'h42) begin errors++; $display("FAIL mis_fault_stable: got %h expected 42", fault_pc); end
        checks++; if (imem_addr !== 7'd1) begin errors++; $display("FAIL mis_pc_ignored_redirect: got %h expected 1", imem_addr); end
        do_reset();
        checks++; if (halted !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL mis_reset_clear: got halted=%b fault=%h expected 0/0", halted, fault_pc); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL mis_restart: got valid=%b pc=%h expected 1/0", out_valid, out_pc); end
    endtask

    task automatic test_end_of_memory();
        fill_pattern();
        do_reset();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1F8;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eom_bubble: got %b expected 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1F8 || out_instr !== 32'h1000_007E) begin errors++; $display("FAIL eom_first: got v=%b pc=%h instr=%h expected 1/1f8/1000007e", out_valid, out_pc, out_instr); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1FC || out_instr !== 32'h1000_007F) begin errors++; $display("FAIL eom_last: got v=%b pc=%h instr=%h expected 1/1fc/1000007f", out_valid, out_pc, out_instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL eom_not_yet_halted: got %b expected 0", halted); end
        cyc();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL eom_halted: got %b expected 1", halted); end
        checks++; if (fault_pc !== 32'h200) begin errors++; $display("FAIL eom_fault_pc: got %h expected 200", fault_pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eom_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_priority();
        fill_pattern();
        do_reset();
        cyc(); cyc();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cyc();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstpri_valid: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 7'd0) begin errors++; $display("FAIL rstpri_pc: got %h expected 0", imem_addr); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin errors++; $display("FAIL rstpri_first_fetch: got v=%b pc=%h instr=%h expected 1/0/10000000", out_valid, out_pc, out_instr); end
        // Reset while the slot is stalled.
        out_ready = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL rstpri_stall: got v=%b pc=%h instr=%h expected 0/0/0", out_valid, out_pc, out_instr); end
    endtask

    // Random ready/redirect traffic. The slot must always present the next
    // instruction of the in-order stream (restarted by each redirect), a
    // redirect costs exactly one empty cycle, and otherwise the slot is full.
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] tgt;
        logic [31:0] nxt;
        logic [31:0] fpc;
        logic [6:0]  frozen_addr;
        logic        prev_rv;
        logic        rv;
        logic        rdy;
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = $urandom;
        do_reset();
        cyc();
        exp_next = 32'h0;
        prev_rv  = 1'b0;
        tgt      = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            if (prev_rv) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_bubble[%0d]: got %b expected 0", i, out_valid); end
                checks++; if (imem_addr !== tgt[8:2]) begin errors++; $display("FAIL rnd_redir_addr[%0d]: got %h expected %h", i, imem_addr, tgt[8:2]); end
            end else begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd_full[%0d]: got %b expected 1", i, out_valid); end
            end
            if (out_valid === 1'b1) begin
                nxt = out_pc + 32'd4;
                checks++; if (out_pc !== exp_next) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, out_pc, exp_next); end
                checks++; if (out_instr !== mem[exp_next[8:2]]) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, out_instr, mem[exp_next[8:2]]); end
                checks++; if (imem_addr !== nxt[8:2]) begin errors++; $display("FAIL rnd_imem_addr[%0d]: got %h expected %h", i, imem_addr, nxt[8:2]); end
            end
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rnd_halted[%0d]: got %b expected 0", i, halted); end

            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 7) == 0) || (exp_next >= 32'h180);
            tgt = {23'h0, 7'($urandom_range(0, 63)), 2'b00};
            out_ready      = rdy;
            redirect_valid = rv;
            redirect_pc    = tgt;
            if (rv) exp_next = tgt;
            else if (out_valid === 1'b1 && rdy) exp_next = exp_next + 32'd4;
            prev_rv = rv;
            cyc();
        end
        // Finish with an illegal target and confirm fetch stays stopped.
        fpc = ($urandom_range(0, 1) == 0) ? (32'h0000_0200 | {$urandom_range(0, 255), 2'b00})
                                          : {$urandom_range(0, 127), 2'b10};
        frozen_addr    = imem_addr;
        redirect_valid = 1'b1;
        redirect_pc    = fpc;
        cyc();
        checks++; if (halted !== 1'b1 || fault_pc !== fpc) begin errors++; $display("FAIL rnd_fault: got halted=%b fault=%h expected 1/%h", halted, fault_pc, fpc); end
        for (int i = 0; i < 20; i++) begin
            out_ready      = $urandom_range(0, 1) == 1;
            redirect_valid = $urandom_range(0, 1) == 1;
            redirect_pc    = {$urandom_range(0, 127), 2'b00};
            cyc();
            checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || fault_pc !== fpc || imem_addr !== frozen_addr) begin
                errors++;
                $display("FAIL rnd_halt_hold[%0d]: got v=%b h=%b fault=%h addr=%h expected 0/1/%h/%h", i, out_valid, halted, fault_pc, imem_addr, fpc, frozen_addr);
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_end_of_memory();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
